// File: rtl/zxuno_regbus_master.sv
// Initiator of the ZX-UNO register bus: decodes the select/data I/O ports and drives the responder strobes.
// Optional address auto-increment after data-port accesses is enabled with `define ZXUNO_ADDR_AUTOINC_EN.
module zxuno_regbus_master #(
   parameter logic [15:0] ADDR_PORT  = 16'hFC3B,
   parameter logic [15:0] DATA_PORT  = 16'hFD3B,
   parameter logic [7:0]  RESET_ADDR = 8'h00
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] a,
   input  logic        iorq_n,
   input  logic        rd_n,
   input  logic        wr_n,
   input  logic [7:0]  din,
   output logic [7:0]  dout,
   output logic        oe_n,
   output logic [7:0]  zxuno_addr,
   output logic        zxuno_regwr,
   output logic        zxuno_regrd,
   input  logic [7:0]  regs_dout,
   input  logic        regs_oe_n
);

   typedef enum logic [1:0] {
      WIN_IDLE = 2'd0,
      WIN_ADDR = 2'd1,
      WIN_DATA = 2'd2
   } win_t;

   win_t       win_q, win_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] dout_q, dout_d;
   logic       regwr_q;

   logic wr_act, rd_act;
   logic sel_a, sel_d;
   logic wr_prev, rd_prev;
   logic wr_start, rd_start, rd_end;

   assign wr_act = ~iorq_n & ~wr_n;
   assign rd_act = ~iorq_n & ~rd_n;
   assign sel_a  = (a == ADDR_PORT);
   assign sel_d  = (a == DATA_PORT);

   // A read overlapping a write is illegal on the Z80; the write wins and no window opens.
   assign wr_start = wr_act & ~wr_prev;
   assign rd_start = rd_act & ~rd_prev & ~wr_act;
   assign rd_end   = ~rd_act & rd_prev;

   // NOTE: every state register uses non-blocking assignments so all flops update from the same pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_prev <= 1'b1;
         rd_prev <= 1'b1;
         win_q   <= WIN_IDLE;
         addr_q  <= RESET_ADDR;
         regwr_q <= 1'b0;
         dout_q  <= 8'hFF;
      end else begin
         wr_prev <= wr_act;
         rd_prev <= rd_act;
         win_q   <= win_d;
         addr_q  <= addr_d;
         regwr_q <= wr_start & sel_d;
         dout_q  <= dout_d;
      end
   end

   // NOTE: defaults are assigned first so no path through the case leaves a signal unassigned (no latch).
   always_comb begin
      win_d = win_q;
      unique case (win_q)
         WIN_IDLE: begin
            if (rd_start && sel_d)      win_d = WIN_DATA;
            else if (rd_start && sel_a) win_d = WIN_ADDR;
         end
         WIN_ADDR, WIN_DATA: begin
            if (rd_end) win_d = WIN_IDLE;
         end
         default: win_d = WIN_IDLE;
      endcase
   end

   // Read data is refreshed every cycle of the window from the port latched at its start.
   always_comb begin
      dout_d = 8'hFF;
      unique case (win_d)
         WIN_ADDR: dout_d = addr_q;
         WIN_DATA: dout_d = regs_oe_n ? 8'hFF : regs_dout;
         default:  dout_d = 8'hFF;
      endcase
   end

`ifdef ZXUNO_ADDR_AUTOINC_EN
   logic wr_end;
   logic wr_data_q;

   assign wr_end = ~wr_act & wr_prev;

   // Remembers that the write in progress targets the data port, so its end can bump the address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_data_q <= 1'b0;
      end else if (wr_start) begin
         wr_data_q <= sel_d;
      end else if (wr_end) begin
         wr_data_q <= 1'b0;
      end
   end

   always_comb begin
      addr_d = addr_q;
      if (wr_start && sel_a) begin
         addr_d = din;
      end else if ((wr_end && wr_data_q) || (rd_end && (win_q == WIN_DATA))) begin
         addr_d = addr_q + 8'd1;
      end
   end
`else
   always_comb begin
      addr_d = addr_q;
      if (wr_start && sel_a) addr_d = din;
   end
`endif

   assign zxuno_addr  = addr_q;
   assign zxuno_regwr = regwr_q;
   assign zxuno_regrd = (win_q == WIN_DATA);
   assign oe_n        = (win_q == WIN_IDLE);
   assign dout        = dout_q;

endmodule

// File: tb/tb_zxuno_regbus_master.sv
// Directed bench for zxuno_regbus_master: vector table of I/O accesses plus hand-written reset,
// overlap and port-latching sequences; the auto-increment sequence runs when ZXUNO_ADDR_AUTOINC_EN is defined.
module tb_zxuno_regbus_master;

   localparam logic [15:0] ADDR_PORT  = 16'hFC3B;
   localparam logic [15:0] DATA_PORT  = 16'hFD3B;
   localparam logic [7:0]  RESET_ADDR = 8'h00;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] a;
   logic        iorq_n, rd_n, wr_n;
   logic [7:0]  din;
   logic [7:0]  dout;
   logic        oe_n;
   logic [7:0]  zxuno_addr;
   logic        zxuno_regwr;
   logic        zxuno_regrd;
   logic [7:0]  regs_dout;
   logic        regs_oe_n;

   int checks = 0;
   int errors = 0;
   logic [7:0] m_addr;

   always #5 clk = ~clk;

   zxuno_regbus_master #(
      .ADDR_PORT (ADDR_PORT),
      .DATA_PORT (DATA_PORT),
      .RESET_ADDR(RESET_ADDR)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .a          (a),
      .iorq_n     (iorq_n),
      .rd_n       (rd_n),
      .wr_n       (wr_n),
      .din        (din),
      .dout       (dout),
      .oe_n       (oe_n),
      .zxuno_addr (zxuno_addr),
      .zxuno_regwr(zxuno_regwr),
      .zxuno_regrd(zxuno_regrd),
      .regs_dout  (regs_dout),
      .regs_oe_n  (regs_oe_n)
   );

   typedef struct {
      logic [15:0] a;
      bit          wr;
      logic [7:0]  wdat;
      int          hold;
      logic [7:0]  rdat;
      logic        roe_n;
      int          exp_regwr;
      int          exp_win;
      int          exp_regrd;
      logic [7:0]  exp_dout;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      iorq_n = 1'b1;
      rd_n   = 1'b1;
      wr_n   = 1'b1;
   endtask

   // Runs one access for `hold` cycles then two idle cycles, tallying what the master drove.
   task automatic io_access(input logic [15:0] addr, input bit wr, input logic [7:0] data, input int hold,
                            output int n_regwr, output int first_regwr, output int n_win,
                            output int n_regrd, output int n_dout_bad,
                            output logic [7:0] dout_seen, output logic [7:0] addr_at_strobe,
                            output logic [7:0] addr_first);
      n_regwr = 0; first_regwr = -1; n_win = 0; n_regrd = 0; n_dout_bad = 0;
      dout_seen = 8'hFF; addr_at_strobe = 8'h00; addr_first = 8'h00;
      a = addr; din = data; iorq_n = 1'b0;
      if (wr) wr_n = 1'b0;
      else    rd_n = 1'b0;
      for (int i = 0; i < hold + 2; i++) begin
         if (i == hold) bus_idle();
         step();
         if (i == 0) addr_first = zxuno_addr;
         if (zxuno_regwr === 1'b1) begin
            n_regwr++;
            if (first_regwr < 0) begin
               first_regwr    = i;
               addr_at_strobe = zxuno_addr;
            end
         end
         if (oe_n === 1'b0) begin
            n_win++;
            dout_seen = dout;
         end else if (dout !== 8'hFF) begin
            n_dout_bad++;
         end
         if (zxuno_regrd === 1'b1) n_regrd++;
      end
   endtask

   initial begin
      int n_regwr, first_regwr, n_win, n_regrd, n_dout_bad;
      logic [7:0] dout_seen, addr_at_strobe, addr_first, pre, exp_dout;

      vecs[0]  = '{ADDR_PORT,   1'b1, 8'h0B, 4, 8'h00, 1'b1, 0, 0, 0, 8'hFF};
      vecs[1]  = '{ADDR_PORT,   1'b0, 8'h00, 3, 8'h00, 1'b1, 0, 3, 0, 8'h00};
      vecs[2]  = '{DATA_PORT,   1'b1, 8'hC5, 6, 8'h00, 1'b1, 1, 0, 0, 8'hFF};
      vecs[3]  = '{DATA_PORT,   1'b0, 8'h00, 4, 8'h5A, 1'b0, 0, 4, 4, 8'h5A};
      vecs[4]  = '{DATA_PORT,   1'b0, 8'h00, 3, 8'h33, 1'b1, 0, 3, 3, 8'hFF};
      vecs[5]  = '{16'h7FFE,    1'b1, 8'h12, 3, 8'h00, 1'b1, 0, 0, 0, 8'hFF};
      vecs[6]  = '{16'h7FFE,    1'b0, 8'h00, 3, 8'h5A, 1'b0, 0, 0, 0, 8'hFF};
      vecs[7]  = '{16'hFE3B,    1'b1, 8'h77, 3, 8'h00, 1'b1, 0, 0, 0, 8'hFF};
      vecs[8]  = '{16'hFE3B,    1'b0, 8'h00, 2, 8'h5A, 1'b0, 0, 0, 0, 8'hFF};
      vecs[9]  = '{ADDR_PORT,   1'b1, 8'hFE, 2, 8'h00, 1'b1, 0, 0, 0, 8'hFF};
      vecs[10] = '{ADDR_PORT,   1'b0, 8'h00, 2, 8'h00, 1'b1, 0, 2, 0, 8'h00};

      rst_n = 1'b0; a = 16'h0000; din = 8'h00; regs_dout = 8'h00; regs_oe_n = 1'b1;
      bus_idle();
      step(); step();
      #3 rst_n = 1'b1;
      step(); step();
      m_addr = RESET_ADDR;

      check("reset addr",  zxuno_addr,  RESET_ADDR);
      check("reset regwr", zxuno_regwr, 1'b0);
      check("reset regrd", zxuno_regrd, 1'b0);
      check("reset oe_n",  oe_n,        1'b1);
      check("reset dout",  dout,        8'hFF);

      for (int k = 0; k < 11; k++) begin
         regs_dout = vecs[k].rdat;
         regs_oe_n = vecs[k].roe_n;
         pre = m_addr;
         io_access(vecs[k].a, vecs[k].wr, vecs[k].wdat, vecs[k].hold, n_regwr, first_regwr,
                   n_win, n_regrd, n_dout_bad, dout_seen, addr_at_strobe, addr_first);
         if (vecs[k].wr && vecs[k].a == ADDR_PORT) m_addr = vecs[k].wdat;
`ifdef ZXUNO_ADDR_AUTOINC_EN
         if (vecs[k].a == DATA_PORT) m_addr = m_addr + 8'd1;
`endif
         // ADDR_PORT reads return whatever register number was selected going in.
         exp_dout = (!vecs[k].wr && vecs[k].a == ADDR_PORT) ? pre : vecs[k].exp_dout;
         check($sformatf("v%0d regwr count", k), n_regwr,    vecs[k].exp_regwr);
         check($sformatf("v%0d window len",  k), n_win,      vecs[k].exp_win);
         check($sformatf("v%0d regrd len",   k), n_regrd,    vecs[k].exp_regrd);
         check($sformatf("v%0d dout",        k), dout_seen,  exp_dout);
         check($sformatf("v%0d idle dout",   k), n_dout_bad, 0);
         check($sformatf("v%0d final addr",  k), zxuno_addr, m_addr);
         if (vecs[k].exp_regwr > 0) begin
            check($sformatf("v%0d strobe cycle", k), first_regwr,    0);
            check($sformatf("v%0d strobe addr",  k), addr_at_strobe, pre);
         end
         if (vecs[k].wr && vecs[k].a == ADDR_PORT)
            check($sformatf("v%0d addr next cycle", k), addr_first, vecs[k].wdat);
      end

      // Port is latched at the start of a read even if the address bus moves.
      regs_dout = 8'h5A; regs_oe_n = 1'b0;
      a = DATA_PORT; iorq_n = 1'b0; rd_n = 1'b0;
      step(); step();
      a = 16'h7FFE;
      step(); step();
      check("latched oe_n",  oe_n,        1'b0);
      check("latched regrd", zxuno_regrd, 1'b1);
      check("latched dout",  dout,        8'h5A);
      bus_idle();
      step();
      check("latched close oe_n", oe_n, 1'b1);
      check("latched close dout", dout, 8'hFF);
      step();
`ifdef ZXUNO_ADDR_AUTOINC_EN
      m_addr = m_addr + 8'd1;
`endif

      // Overlapping read and write: one strobe, no window.
      a = DATA_PORT; din = 8'h99; iorq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
      n_regwr = 0; n_win = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (zxuno_regwr === 1'b1) n_regwr++;
         if (oe_n === 1'b0) n_win++;
      end
      bus_idle();
      step(); step();
`ifdef ZXUNO_ADDR_AUTOINC_EN
      m_addr = m_addr + 8'd1;
`endif
      check("overlap regwr count", n_regwr,    1);
      check("overlap window",      n_win,      0);
      check("overlap addr",        zxuno_addr, m_addr);

      // Reset during a data read closes the window at once; the ongoing access is ignored afterwards.
      a = ADDR_PORT; din = 8'h3C; iorq_n = 1'b0; wr_n = 1'b0;
      step();
      bus_idle();
      step(); step();
      m_addr = 8'h3C;
`ifdef ZXUNO_ADDR_AUTOINC_EN
      check("pre-reset addr", zxuno_addr, m_addr);
`endif
      a = DATA_PORT; iorq_n = 1'b0; rd_n = 1'b0;
      step(); step();
      check("pre-reset oe_n", oe_n, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("mid-read reset oe_n",  oe_n,        1'b1);
      check("mid-read reset regrd", zxuno_regrd, 1'b0);
      check("mid-read reset dout",  dout,        8'hFF);
      check("mid-read reset addr",  zxuno_addr,  RESET_ADDR);
      m_addr = RESET_ADDR;
      step();
      #2 rst_n = 1'b1;
      n_win = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (oe_n === 1'b0) n_win++;
      end
      check("held read after reset", n_win, 0);
      bus_idle();
      step();
      iorq_n = 1'b0; rd_n = 1'b0;
      step();
      check("new read oe_n",  oe_n,        1'b0);
      check("new read regrd", zxuno_regrd, 1'b1);
      bus_idle();
      step(); step();
`ifdef ZXUNO_ADDR_AUTOINC_EN
      m_addr = m_addr + 8'd1;
`endif
      check("after new read addr", zxuno_addr, m_addr);

      // A strobe already issued is cut short by reset.
      a = DATA_PORT; din = 8'h44; iorq_n = 1'b0; wr_n = 1'b0;
      step();
      check("strobe before reset", zxuno_regwr, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      check("strobe cancelled", zxuno_regwr, 1'b0);
      m_addr = RESET_ADDR;
      bus_idle();
      step();
      #2 rst_n = 1'b1;
      step(); step();
      check("post-cancel addr", zxuno_addr, m_addr);

`ifdef ZXUNO_ADDR_AUTOINC_EN
      io_access(ADDR_PORT, 1'b1, 8'hFE, 2, n_regwr, first_regwr, n_win, n_regrd, n_dout_bad,
                dout_seen, addr_at_strobe, addr_first);
      check("inc set addr", zxuno_addr, 8'hFE);
      io_access(DATA_PORT, 1'b1, 8'hAA, 3, n_regwr, first_regwr, n_win, n_regrd, n_dout_bad,
                dout_seen, addr_at_strobe, addr_first);
      check("inc wr1 strobe addr", addr_at_strobe, 8'hFE);
      check("inc wr1 final addr",  zxuno_addr,     8'hFF);
      io_access(DATA_PORT, 1'b1, 8'hBB, 3, n_regwr, first_regwr, n_win, n_regrd, n_dout_bad,
                dout_seen, addr_at_strobe, addr_first);
      check("inc wr2 strobe addr", addr_at_strobe, 8'hFF);
      check("inc wr2 wrap addr",   zxuno_addr,     8'h00);
      a = DATA_PORT; iorq_n = 1'b0; rd_n = 1'b0;
      step(); step();
      check("inc read regrd", zxuno_regrd, 1'b1);
      check("inc read addr",  zxuno_addr,  8'h00);
      bus_idle();
      step(); step();
      check("inc final addr", zxuno_addr, 8'h01);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/zxuno_regbus_master.md
Name: zxuno_regbus_master

Overview:
- Initiator side of the ZX-UNO internal register bus.
- Decodes Z80 I/O accesses to the register-select port and the register-data port, and holds the current register number on zxuno_addr.
- Produces the zxuno_regwr/zxuno_regrd strobes that every register responder (scandoubler control, etc.) decodes.
- Returns responder read data to the CPU data bus.

Parameters:
- ADDR_PORT, 16'hFC3B, I/O address of the register-select port (R/W).
- DATA_PORT, 16'hFD3B, I/O address of the register-data port (R/W).
- RESET_ADDR, 8'h00, value loaded into zxuno_addr on reset.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a  in  16  Z80 address bus.
- iorq_n  in  1  Z80 IORQ, active low.
- rd_n  in  1  Z80 RD, active low.
- wr_n  in  1  Z80 WR, active low.
- din  in  8  Z80 data bus, CPU to device.
- dout  out  8  data to CPU during reads of ADDR_PORT/DATA_PORT.
- oe_n  out  1  active low; dout valid, claim the CPU bus.
- zxuno_addr  out  8  currently selected register number.
- zxuno_regwr  out  1  one-cycle write strobe to responders.
- zxuno_regrd  out  1  read-enable level to responders.
- regs_dout  in  8  OR-muxed read data from responders.
- regs_oe_n  in  1  active low; some responder drives regs_dout.

Behaviour:
- Reset is asynchronous and active-low.
  - zxuno_addr=RESET_ADDR; zxuno_regwr=0; zxuno_regrd=0; oe_n=1; dout=8'hFF.
  - Both access-history flags are set to 1 (busy).
- Bus decode each clk:
  - wr_act = !iorq_n & !wr_n
  - rd_act = !iorq_n & !rd_n
  - sel_a = (a==ADDR_PORT); sel_d = (a==DATA_PORT)
- History registers wr_prev <= wr_act and rd_prev <= rd_act are updated every cycle.
  - wr_start = wr_act & !wr_prev; rd_start = rd_act & !rd_prev.
  - rd_end = !rd_act & rd_prev; wr_end = !wr_act & wr_prev.
- Because history resets to 1, an access already in progress when rst_n rises is ignored. The bus must be seen idle for one cycle before any start is recognised.
- Write to ADDR_PORT: on the wr_start cycle with sel_a, zxuno_addr <= din. Visible to responders the next cycle.
- Write to DATA_PORT: on the wr_start cycle with sel_d, zxuno_regwr <= 1 for exactly one clk.
  - zxuno_addr is unchanged.
  - din must remain stable through the following cycle; the CPU write cycle guarantees this.
- Held writes produce only one strobe, regardless of write length.
- Read window (level):
  - From the cycle after rd_start with sel_d until the cycle after rd_end: zxuno_regrd=1 and oe_n=0.
  - Same window for sel_a, but oe_n=0 with zxuno_regrd kept 0.
  - The selected port is latched at rd_start and used for the whole window, even if a changes.
- dout is registered every cycle while the window is open:
  - ADDR_PORT window: zxuno_addr.
  - DATA_PORT window: regs_dout if regs_oe_n==0, else 8'hFF (unimplemented register).
  - Outside any window: dout=8'hFF.
- Accesses to other addresses produce no strobes, no window, and no state change.
- Simultaneous rd_act & wr_act is illegal on Z80. If it occurs, the write takes priority and no read window opens.
- Reset asserted mid-read closes the window immediately (oe_n=1, zxuno_regrd=0). A pending regwr strobe is cancelled.

Optional Feature:
- Macro: ZXUNO_ADDR_AUTOINC_EN.
- With the macro defined:
  - zxuno_addr <= zxuno_addr+1 (8-bit, 8'hFF wraps to 8'h00) on the wr_end or rd_end cycle of a DATA_PORT access.
  - The increment happens after the strobe or window, so the accessed register is always the pre-increment one.
  - Writes to ADDR_PORT never increment.
- Without the macro: zxuno_addr changes only on ADDR_PORT writes and reset.

Test Plan:
- Reset, then IO write 8'h0B to FC3B (4 clk) -> zxuno_addr=8'h0B from the cycle after the start; zxuno_regwr never asserts; read FC3B -> oe_n=0, dout=8'h0B.
- With zxuno_addr=8'h0B, IO write 8'hC5 to FD3B held 6 clk -> exactly one zxuno_regwr pulse, one cycle after the start, with din=8'hC5; zxuno_addr stays 8'h0B (macro off).
- Read FD3B with responder regs_oe_n=0, regs_dout=8'h5A -> zxuno_regrd=1 and oe_n=0 from start+1 to end+1; dout=8'h5A. Repeat with regs_oe_n=1 -> dout=8'hFF.
- IO write/read to 16'h7FFE and 16'hFE3B -> no regwr, zxuno_regrd=0, oe_n=1, zxuno_addr unchanged.
- Assert rst_n=0 mid FD3B read, release while rd_n still low -> window closes at once, no new window until rd_n/iorq_n go high then low again; zxuno_addr=RESET_ADDR.
- ZXUNO_ADDR_AUTOINC_EN: set addr 8'hFE, write FD3B twice, then read FD3B -> regwr at 8'hFE then 8'hFF; read at addr 8'h00; final zxuno_addr=8'h01.
